// File: rtl/tone_sequencer.sv
// Table-driven melody player: walks {divisor, duration_ms} entries and gates the tone.
// Optional build macro TONE_SEQ_LOOP_EN repeats the table until stop instead of finishing.
module tone_sequencer #(
    parameter int STEPS    = 8,
    parameter int DIV_BITS = 8,
    parameter int DUR_BITS = 16,
    parameter int TICK_MAX = 12000,
    localparam int AW      = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int TW      = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DIV_BITS-1:0] wr_div,
    input  logic [DUR_BITS-1:0] wr_dur,
    output logic [DIV_BITS-1:0] tone_div,
    output logic                tone_en,
    output logic [AW-1:0]       step_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(STEPS - 1);

    state_t              state;
    logic [AW-1:0]       step;
    logic [TW-1:0]       tick_cnt;
    logic [DUR_BITS-1:0] ms_cnt;
    logic [DUR_BITS-1:0] cur_dur;

    logic [DIV_BITS-1:0] div_mem [STEPS];
    logic [DUR_BITS-1:0] dur_mem [STEPS];

    assign step_idx = step;

    // Table is left unreset and frozen while a sequence is running.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            div_mem[wr_addr] <= wr_div;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            tone_div <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            cur_dur  <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                tone_en <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= LOAD;
                            step  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (dur_mem[step] == '0) begin
`ifdef TONE_SEQ_LOOP_EN
                            // A marker past step 0 wraps; at step 0 the table is empty.
                            if (step != '0) begin
                                step <= '0;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
`else
                            state <= FINISH;
                            done  <= 1'b1;
`endif
                        end else begin
                            tone_div <= div_mem[step];
                            cur_dur  <= dur_mem[step];
                            tick_cnt <= '0;
                            ms_cnt   <= '0;
                            tone_en  <= 1'b1;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (ms_cnt == cur_dur - DUR_BITS'(1)) begin
                                tone_en <= 1'b0;
                                if (step == STEP_LAST) begin
`ifdef TONE_SEQ_LOOP_EN
                                    step  <= '0;
                                    state <= LOAD;
`else
                                    state <= FINISH;
                                    done  <= 1'b1;
`endif
                                end else begin
                                    step  <= step + AW'(1);
                                    state <= LOAD;
                                end
                            end else begin
                                ms_cnt <= ms_cnt + DUR_BITS'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
